// File: rtl/cnn_pkg.sv
// Shared types and default widths for the CNN kernel/bias loading path.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  localparam int DEF_DATA_WIDTH                     = 32;
  localparam int DEF_KERNEL_BRAM_NUM                = 4;
  localparam int DEF_KERNEL_BIAS_WIDTH              = 8;
  localparam int DEF_KERNEL_BIAS_BRAM_ADDRESS_WIDTH = 6;

  // A single bank still needs a 1-bit index so the counter ports stay legal.
  function automatic int bank_index_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/kernel_bias_bank_counter.sv
// Bank-major write cursor: address runs 0..size-1 within a bank, then moves to the next bank.
module kernel_bias_bank_counter
  import cnn_pkg::*;
#(
  parameter int KERNEL_BRAM_NUM   = DEF_KERNEL_BRAM_NUM,
  parameter int KERNEL_BIAS_WIDTH = DEF_KERNEL_BIAS_WIDTH,
  parameter int ADDRESS_WIDTH     = DEF_KERNEL_BIAS_BRAM_ADDRESS_WIDTH,
  parameter int BANK_W            = bank_index_width(DEF_KERNEL_BRAM_NUM)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         advance,
  input  logic [KERNEL_BIAS_WIDTH-1:0] size,
  output logic [ADDRESS_WIDTH-1:0]     address,
  output logic [BANK_W-1:0]            bank,
  output logic                         last_word
);

  logic addr_end;

  assign addr_end  = (32'(address) + 32'd1) == 32'(size);
  assign last_word = addr_end && (32'(bank) == 32'(KERNEL_BRAM_NUM - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address <= '0;
      bank    <= '0;
    end else if (clear) begin
      address <= '0;
      bank    <= '0;
    end else if (advance) begin
      if (addr_end) begin
        address <= '0;
        bank    <= bank + BANK_W'(1);
      end else begin
        address <= address + ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/kernel_bias_loader.sv
// Streams size*KERNEL_BRAM_NUM words into the kernel/bias BRAM banks, bank-major.
// Optional running checksum output enabled by KERNEL_BIAS_LOADER_CHECKSUM_EN.
module kernel_bias_loader
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH                     = DEF_DATA_WIDTH,
  parameter int KERNEL_BRAM_NUM                = DEF_KERNEL_BRAM_NUM,
  parameter int KERNEL_BIAS_WIDTH              = DEF_KERNEL_BIAS_WIDTH,
  parameter int KERNEL_BIAS_BRAM_ADDRESS_WIDTH = DEF_KERNEL_BIAS_BRAM_ADDRESS_WIDTH
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  input  logic [KERNEL_BIAS_WIDTH-1:0]              i_kernel_bias_size,
  input  logic                                      i_s_valid,
  output logic                                      o_s_ready,
  input  logic [DATA_WIDTH-1:0]                     i_s_data,
  output logic                                      o_ps_enable [KERNEL_BRAM_NUM],
  output logic                                      o_wenable   [KERNEL_BRAM_NUM],
  output logic [KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] o_waddress  [KERNEL_BRAM_NUM],
  output logic [DATA_WIDTH-1:0]                     o_bram_data [KERNEL_BRAM_NUM],
  output logic [KERNEL_BRAM_NUM-1:0]                o_kernel_bias_bram_rst,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_error
`ifdef KERNEL_BIAS_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]                     o_checksum
`endif
);

  localparam int          BANK_W    = bank_index_width(KERNEL_BRAM_NUM);
  localparam logic [31:0] MAX_WORDS = 32'(1) << KERNEL_BIAS_BRAM_ADDRESS_WIDTH;

  loader_state_t state, state_next;

  logic [KERNEL_BIAS_WIDTH-1:0]              size_q;
  logic                                      size_bad;
  logic                                      xfer;
  logic [KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] cnt_address;
  logic [BANK_W-1:0]                         cnt_bank;
  logic                                      cnt_last;
  logic                                      done_q;
  logic                                      error_q;

  logic                                      vld_p1   [KERNEL_BRAM_NUM];
  logic [KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] waddr_p1 [KERNEL_BRAM_NUM];
  logic [DATA_WIDTH-1:0]                     wdata_p1 [KERNEL_BRAM_NUM];

  assign size_bad = (size_q == '0) || (32'(size_q) > MAX_WORDS);
  assign xfer     = (state == ST_LOAD) && i_s_valid;

  kernel_bias_bank_counter #(
    .KERNEL_BRAM_NUM  (KERNEL_BRAM_NUM),
    .KERNEL_BIAS_WIDTH(KERNEL_BIAS_WIDTH),
    .ADDRESS_WIDTH    (KERNEL_BIAS_BRAM_ADDRESS_WIDTH),
    .BANK_W           (BANK_W)
  ) u_bank_counter (
    .clock    (i_clock),
    .reset_n  (i_reset),
    .clear    (state == ST_CLEAR),
    .advance  (xfer),
    .size     (size_q),
    .address  (cnt_address),
    .bank     (cnt_bank),
    .last_word(cnt_last)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_CLEAR;
      ST_CLEAR: state_next = size_bad ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (xfer && cnt_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // DONE still counts as busy: it is the cycle carrying the final write.
  always_comb begin
    o_s_ready              = 1'b0;
    o_busy                 = 1'b0;
    o_kernel_bias_bram_rst = '0;
    case (state)
      ST_CLEAR: begin
        o_kernel_bias_bram_rst = '1;
        o_busy                 = 1'b1;
      end
      ST_LOAD: begin
        o_s_ready = 1'b1;
        o_busy    = 1'b1;
      end
      ST_DONE:  o_busy = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      size_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (state == ST_IDLE && i_start) begin
        size_q  <= i_kernel_bias_size;
        error_q <= 1'b0;
      end else if (state == ST_CLEAR && size_bad) begin
        error_q <= 1'b1;
      end
    end
  end

  assign o_done  = done_q;
  assign o_error = error_q;

  // Stage p1: a word accepted in cycle t is written to its bank in cycle t+1.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
        vld_p1[b]   <= 1'b0;
        waddr_p1[b] <= '0;
        wdata_p1[b] <= '0;
      end
    end else begin
      for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
        vld_p1[b] <= xfer && (cnt_bank == BANK_W'(b));
        if (xfer && (cnt_bank == BANK_W'(b))) begin
          waddr_p1[b] <= cnt_address;
          wdata_p1[b] <= i_s_data;
        end
      end
    end
  end

  assign o_ps_enable = vld_p1;
  assign o_wenable   = vld_p1;
  assign o_waddress  = waddr_p1;
  assign o_bram_data = wdata_p1;

`ifdef KERNEL_BIAS_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)               checksum_q <= '0;
    else if (state == ST_CLEAR) checksum_q <= '0;
    else if (xfer)              checksum_q <= checksum_q + i_s_data;
  end

  assign o_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_kernel_bias_loader.sv
// Directed-plus-random bench for kernel_bias_loader; words land in a scoreboard memory per bank.
`timescale 1ns/1ps
module tb_kernel_bias_loader;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int KW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [KW-1:0] i_size;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [DW-1:0] i_s_data;
  logic          ps_en   [NB];
  logic          wen     [NB];
  logic [AW-1:0] waddr   [NB];
  logic [DW-1:0] wdata   [NB];
  logic [NB-1:0] bram_rst;
  logic          o_busy, o_done, o_error;
`ifdef KERNEL_BIAS_LOADER_CHECKSUM_EN
  logic [DW-1:0] o_checksum;
`endif

  kernel_bias_loader dut (
    .i_clock               (clk),
    .i_reset               (rst_n),
    .i_start               (i_start),
    .i_kernel_bias_size    (i_size),
    .i_s_valid             (i_s_valid),
    .o_s_ready             (o_s_ready),
    .i_s_data              (i_s_data),
    .o_ps_enable           (ps_en),
    .o_wenable             (wen),
    .o_waddress            (waddr),
    .o_bram_data           (wdata),
    .o_kernel_bias_bram_rst(bram_rst),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_error               (o_error)
`ifdef KERNEL_BIAS_LOADER_CHECKSUM_EN
    ,
    .o_checksum            (o_checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard fed by the write ports; cleared whenever a new load is begun.
  logic [DW-1:0] obs_mem [NB][64];
  bit            obs_set [NB][64];
  int n_writes, n_dup, n_bad, n_done, n_rst_cyc, n_nobusy;
  int load_id = 0;
  int seen_id = 0;

  always @(negedge clk) begin
    int hot;
    if (seen_id != load_id) begin
      seen_id = load_id;
      n_writes = 0; n_dup = 0; n_bad = 0; n_done = 0; n_rst_cyc = 0; n_nobusy = 0;
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 64; a++) begin
          obs_set[b][a] = 1'b0;
          obs_mem[b][a] = '0;
        end
    end
    hot = 0;
    for (int b = 0; b < NB; b++) begin
      if (wen[b] !== ps_en[b]) n_bad++;
      if (wen[b] === 1'b1) begin
        hot++;
        if (obs_set[b][waddr[b]]) n_dup++;
        obs_set[b][waddr[b]] = 1'b1;
        obs_mem[b][waddr[b]] = wdata[b];
        n_writes++;
      end
    end
    if (hot > 1) n_bad++;
    if (hot > 0 && o_busy !== 1'b1) n_nobusy++;
    if (o_done === 1'b1) n_done++;
    if (&bram_rst) n_rst_cyc++;
    else if (|bram_rst) n_bad++;
  end

  logic [DW-1:0] words [256];
  int start_cyc;
  logic [DW-1:0] done_checksum;

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  task automatic begin_load(input int size);
    @(posedge clk); #1;
    load_id++;
    i_size  = KW'(size);
    i_start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 20 && dcyc < 0; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) dcyc = cyc;
    end
  endtask

  // mode 0: valid always high, 1: valid toggles each cycle, 2: random valid.
  task automatic run_load(input string tag, input int size, input int mode, input bit noisy_start);
    int total, k, last_x, budget, dcyc, ph;
    logic [DW-1:0] sum;
    bit v;
    total = size * NB; k = 0; last_x = -100; budget = total * 4 + 20; ph = 0; sum = '0;
    begin_load(size);
    while (k < total && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ph[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph++;
      i_s_valid = v;
      i_s_data  = words[k];
      if (noisy_start) begin
        i_start = 1'($urandom_range(0, 1));
        i_size  = KW'($urandom);
      end
      @(negedge clk);
      if (v && o_s_ready === 1'b1) begin
        last_x = cyc;
        sum    = sum + words[k];
        k++;
      end
      @(posedge clk); #1;
      budget--;
    end
    i_s_valid = 1'b0;
    i_start   = 1'b0;
    check({tag, "_xfer_count"}, k, total);
    wait_done(dcyc);
    check({tag, "_done_latency"}, dcyc - last_x, 2);
    check({tag, "_ready_after"}, o_s_ready, 1'b0);
    check({tag, "_busy_after"}, o_busy, 1'b0);
    check({tag, "_error"}, o_error, 1'b0);
`ifdef KERNEL_BIAS_LOADER_CHECKSUM_EN
    done_checksum = o_checksum;
    check({tag, "_checksum"}, o_checksum, sum);
`endif
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_writes"}, n_writes, total);
    check({tag, "_dup_writes"}, n_dup, 0);
    check({tag, "_bank_onehot"}, n_bad, 0);
    check({tag, "_busy_on_write"}, n_nobusy, 0);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_bram_rst_cycles"}, n_rst_cyc, 1);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < size; a++)
        check($sformatf("%s_mem_b%0d_a%0d", tag, b, a),
              obs_set[b][a] ? {32'd0, obs_mem[b][a]} : 64'hdead_0000_0000_0000,
              {32'd0, words[b * size + a]});
  endtask

  task automatic run_error(input string tag, input int size);
    int dcyc;
    begin_load(size);
    wait_done(dcyc);
    check({tag, "_done_latency"}, dcyc - start_cyc, 3);
    check({tag, "_error_at_done"}, o_error, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_writes"}, n_writes, 0);
    check({tag, "_bram_rst_cycles"}, n_rst_cyc, 1);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_error_sticky"}, o_error, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    logic any_wr;
    any_wr = 1'b0;
    for (int b = 0; b < NB; b++)
      any_wr = any_wr | wen[b] | ps_en[b] | (|waddr[b]) | (|wdata[b]);
    check({tag, "_ready"}, o_s_ready, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_error"}, o_error, 1'b0);
    check({tag, "_bram_rst"}, bram_rst, '0);
    check({tag, "_write_ports"}, any_wr, 1'b0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; i_start = 1'b0; i_size = '0; i_s_valid = 1'b0; i_s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) words[i] = 32'h11 + i;
    run_load("dir_valid", 2, 0, 1'b0);
    run_load("dir_toggle", 2, 1, 1'b0);

    run_error("size0", 0);
    fill_random(8);
    run_load("restart_ignored", 2, 2, 1'b1);

    run_error("size65", 65);
    fill_random(256);
    run_load("size64", 64, 0, 1'b0);
    fill_random(4);
    run_load("size1", 1, 2, 1'b1);

    // Abandon a size-4 load after three words, with reset asserted mid-cycle.
    fill_random(16);
    begin_load(4);
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      i_s_valid = 1'b1;
      i_s_data  = words[k];
      @(negedge clk);
      if (o_s_ready === 1'b1) k++;
      @(posedge clk); #1;
    end
    i_s_valid = 1'b0;
    check("abort_pre_wen0", wen[0], 1'b1);
    check("abort_pre_waddr0", waddr[0], 2);
    check("abort_pre_wdata0", wdata[0], words[2]);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random(16);
    run_load("reload", 4, 2, 1'b0);

    for (int i = 0; i < 8; i++) words[i] = i + 1;
    run_load("sum_1to8", 2, 0, 1'b0);
`ifdef KERNEL_BIAS_LOADER_CHECKSUM_EN
    check("checksum_36", done_checksum, 36);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_bias_loader.md
KERNEL_BIAS_LOADER -- requirements
Module: kernel_bias_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, BRAM word width.
REQ-002 SHALL have parameter KERNEL_BRAM_NUM, default 4, number of kernel/bias banks.
REQ-003 SHALL have parameter KERNEL_BIAS_WIDTH, default 8, width of the per-bank word count.
REQ-004 SHALL have parameter KERNEL_BIAS_BRAM_ADDRESS_WIDTH, default 6, bank write-address width.
REQ-005 SHALL have ports, clock and reset first:
- i_clock  in  1  single clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  load request pulse.
- i_kernel_bias_size  in  KERNEL_BIAS_WIDTH  words per bank.
- i_s_valid  in  1  stream word valid.
- o_s_ready  out  1  loader accepts a word.
- i_s_data  in  DATA_WIDTH  stream word.
- o_ps_enable  out  1 x KERNEL_BRAM_NUM (unpacked)  port-A enable per bank.
- o_wenable  out  1 x KERNEL_BRAM_NUM (unpacked)  port-A write enable per bank.
- o_waddress  out  KERNEL_BIAS_BRAM_ADDRESS_WIDTH x KERNEL_BRAM_NUM (unpacked)  write address per bank.
- o_bram_data  out  DATA_WIDTH x KERNEL_BRAM_NUM (unpacked)  write data per bank.
- o_kernel_bias_bram_rst  out  KERNEL_BRAM_NUM  port-A reset per bank.
- o_busy  out  1  load in progress.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  sticky error for last load.

Function
REQ-006 SHALL implement FSM IDLE -> CLEAR -> LOAD -> DONE -> IDLE.
REQ-007 IDLE: i_start=1 SHALL latch i_kernel_bias_size, clear o_error, enter CLEAR; i_start outside IDLE is ignored.
REQ-008 CLEAR (1 cycle): o_kernel_bias_bram_rst SHALL be all ones; next state LOAD, or DONE with o_error=1 if latched size is 0 or exceeds 2^KERNEL_BIAS_BRAM_ADDRESS_WIDTH.
REQ-009 LOAD: o_s_ready SHALL be 1; a word transfers when i_s_valid and o_s_ready are both 1.
REQ-010 Order SHALL be bank-major: words 0..size-1 to bank 0 addresses 0..size-1, then bank 1, ..., total size*KERNEL_BRAM_NUM words.
REQ-011 Transfer in cycle t SHALL produce, in cycle t+1 only, o_ps_enable[b]=o_wenable[b]=1 for the target bank b, o_waddress[b]=address, o_bram_data[b]=word; all other banks' enables 0.
REQ-012 Address SHALL wrap to 0 and bank increment when address reaches size-1; valid gaps produce no write and no counter change.
REQ-013 After the final transfer, o_s_ready SHALL drop the next cycle; the FSM enters DONE in cycle t+1 (final write) and o_done pulses in cycle t+2.
REQ-014 o_busy SHALL be 1 from the CLEAR cycle through the final write cycle inclusive.
REQ-015 Error path: DONE SHALL pulse o_done with no writes; o_error holds until next accepted i_start.
REQ-016 o_ps_enable/o_wenable SHALL never be asserted for more than one bank per cycle.

Reset
REQ-017 i_reset=0 SHALL immediately force IDLE, counters 0, and all outputs 0 (o_s_ready, enables, addresses, data, bram_rst, o_busy, o_done, o_error).
REQ-018 Reset mid-LOAD SHALL abandon the load; BRAM contents are undefined until a full reload completes.

Configuration
REQ-019 With KERNEL_BIAS_LOADER_CHECKSUM_EN defined, SHALL add output o_checksum (DATA_WIDTH), cleared in CLEAR, adding each transferred word modulo 2^DATA_WIDTH, stable from o_done until next start.
REQ-020 Without KERNEL_BIAS_LOADER_CHECKSUM_EN, port and adder SHALL be absent; all other behaviour identical.

Structure
REQ-021 FSM state enum and default width constants SHALL live in shared package cnn_pkg.
REQ-022 Address/bank counting SHALL be sub-module kernel_bias_bank_counter (increment, wrap at size-1, last-word flag).

Verification
REQ-023 size=2, 8 words 0x11..0x18 always valid -> bank0 a0=0x11 a1=0x12, bank1 0x13/0x14, bank2 0x15/0x16, bank3 0x17/0x18; o_done 2 cycles after 8th transfer.
REQ-024 same, i_s_valid toggling every cycle -> identical writes, no duplicates, one write per transfer.
REQ-025 size=0 -> bram_rst 1 cycle, o_error=1, o_done on 3rd cycle after start, zero writes.
REQ-026 i_start repeated during LOAD -> ignored, single o_done, counts unchanged.
REQ-027 reset after 3 transfers of a size=4 load -> all outputs 0 same cycle; restart loads 16 words correctly.
REQ-028 with CHECKSUM_EN, words 1..8 -> o_checksum=36 at o_done.
